// File: rtl/bios_arb_pkg.sv
// Shared IDs, arbitration modes and counter sizing for the BIOS RAM port arbiter.
// Pure definitions: no latency, no flow control.
// Imported by bios_port_arbiter and bios_arb_pick.
package bios_arb_pkg;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int STARVE_W = 8;

    function automatic logic starved(input logic [STARVE_W-1:0] cnt, input int limit);
        return cnt >= STARVE_W'(limit);
    endfunction

endpackage

// File: rtl/bios_arb_pick.sv
// Two-way grant picker: requests, last-grant pointer, mode, starvation force and lock in; grant out.
// Latency: purely combinational, decision in the same cycle.
// Backpressure: a master not granted simply keeps its request up; nothing is stored here.
module bios_arb_pick
    import bios_arb_pkg::*;
(
    input  logic      req0_i,
    input  logic      req1_i,
    input  logic      last_i,
    input  arb_mode_e mode_i,
    input  logic      force_i,
    input  logic      lock_i,
    output logic      gnt_vld_o,
    output logic      gnt_id_o
);

    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_id_o  = ID_M0;
        // A held lock reserves the port for M1 even while M1 is idle.
        if (lock_i) begin
            gnt_vld_o = req1_i;
            gnt_id_o  = ID_M1;
        end else if (req0_i && req1_i) begin
            gnt_vld_o = 1'b1;
            if (mode_i == ARB_RR) begin
                gnt_id_o = ~last_i;
            end else begin
                gnt_id_o = force_i ? ID_M1 : ID_M0;
            end
        end else if (req0_i) begin
            gnt_vld_o = 1'b1;
            gnt_id_o  = ID_M0;
        end else if (req1_i) begin
            gnt_vld_o = 1'b1;
            gnt_id_o  = ID_M1;
        end
    end

endmodule

// File: rtl/bios_port_arbiter.sv
// Shares one synchronous-read BIOS RAM port between M0 (CPU) and M1 (debug/loader).
// Latency: ack and mem_* in the request cycle; rvalid/rdata one cycle after ack.
// Backpressure: the losing master holds req until ack; one access per cycle in total.
module bios_port_arbiter
    import bios_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = 12,
    parameter int PRIORITY_MODE = 0,
    parameter int STARVE_LIMIT  = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_we,
    output logic                  m0_ack,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_we,
    output logic                  m1_ack,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    input  logic                  m1_lock,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [3:0]            mem_we,
    input  logic [31:0]           mem_dout
);

    localparam arb_mode_e MODE = (PRIORITY_MODE == 1) ? ARB_FIXED : ARB_RR;

    logic                ptr_q, ptr_d;
    logic [STARVE_W-1:0] cnt_q, cnt_d;
    logic                lock_q, lock_d;
    logic                tag_vld_q, tag_vld_d;
    logic                tag_id_q, tag_id_d;
    logic [31:0]         rdata0_q, rdata0_d;
    logic [31:0]         rdata1_q, rdata1_d;

    logic lock_eff;
    logic force_m1;
    logic pick_vld;
    logic gnt_id;
    logic gnt_vld;
    logic sel_m1;

    // The lock releases in the very cycle m1_lock drops, so M0 can win that cycle.
    assign lock_eff = lock_q & m1_lock;
    assign force_m1 = (MODE == ARB_FIXED) && starved(cnt_q, STARVE_LIMIT);

    bios_arb_pick u_pick (
        .req0_i    (m0_req),
        .req1_i    (m1_req),
        .last_i    (ptr_q),
        .mode_i    (MODE),
        .force_i   (force_m1),
        .lock_i    (lock_eff),
        .gnt_vld_o (pick_vld),
        .gnt_id_o  (gnt_id)
    );

    assign gnt_vld = pick_vld & rstn;
    assign sel_m1  = gnt_vld & (gnt_id == ID_M1);

    assign m0_ack   = gnt_vld & (gnt_id == ID_M0);
    assign m1_ack   = sel_m1;
    assign mem_en   = gnt_vld;
    assign mem_addr = sel_m1 ? m1_addr  : m0_addr;
    assign mem_din  = sel_m1 ? m1_wdata : m0_wdata;
    assign mem_we   = !gnt_vld ? 4'h0 : (sel_m1 ? m1_we : m0_we);

    // A response due while reset is asserted is dropped rather than issued.
    assign m0_rvalid = rstn & tag_vld_q & (tag_id_q == ID_M0);
    assign m1_rvalid = rstn & tag_vld_q & (tag_id_q == ID_M1);
    assign m0_rdata  = m0_rvalid ? mem_dout : rdata0_q;
    assign m1_rdata  = m1_rvalid ? mem_dout : rdata1_q;

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        lock_d    = lock_q;
        tag_vld_d = gnt_vld;
        tag_id_d  = gnt_id;
        rdata0_d  = m0_rdata;
        rdata1_d  = m1_rdata;
        if (gnt_vld) begin
            ptr_d = gnt_id;
        end
        if (!lock_eff) begin
            if (m1_ack) begin
                cnt_d = '0;
            end else if (m1_req && (cnt_q != '1)) begin
                cnt_d = cnt_q + STARVE_W'(1);
            end
        end
        if (lock_q && !m1_lock) begin
            lock_d = 1'b0;
        end
        if (m1_ack && m1_lock) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q     <= ID_M1;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            tag_vld_q <= 1'b0;
            tag_id_q  <= ID_M0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

endmodule
